// File: rtl/bfm_apbtoahb.sv
// APB completer to single-master AHB-Lite bridge: one SINGLE word transfer per APB access.
// Define APB2AHB_PSLVERR_EN to forward AHB ERROR responses as PSLVERR.
module bfm_apbtoahb (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] prdata_q, prdata_d;
  logic        hwrite_q, hwrite_d;
  logic        err_q, err_d;
  logic        unused_ok;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      prdata_q <= '0;
      hwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      prdata_q <= prdata_d;
      hwrite_q <= hwrite_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    prdata_d = prdata_q;
    hwrite_d = hwrite_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        // PENABLE without a setup phase is not a new access
        if (PSEL && !PENABLE) begin
          haddr_d  = {PADDR[31:2], 2'b00};
          hwrite_d = PWRITE;
          hwdata_d = PWDATA;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (HREADY) state_d = DATA;
      end
      DATA: begin
        if (HREADY) begin
          if (!hwrite_q) prdata_d = HRDATA;
          err_d   = HRESP;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign HTRANS    = (state_q == ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign PRDATA    = prdata_q;
  assign PREADY    = (state_q == RESP);

`ifdef APB2AHB_PSLVERR_EN
  assign PSLVERR   = (state_q == RESP) && err_q;
  assign unused_ok = ^PADDR[1:0];
`else
  // APB2-style completer: the captured error is absorbed
  assign PSLVERR   = 1'b0;
  assign unused_ok = ^{PADDR[1:0], err_q};
`endif

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// Randomized scoreboard bench for bfm_apbtoahb with a behavioural AHB slave
// and a transaction-level reference model.
module tb_bfm_apbtoahb;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  bfm_apbtoahb dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

`ifdef APB2AHB_PSLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          astall;
    int          dwait;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          lat;
  } apb_exp_t;

  plan_t       plan_q[$];
  plan_t       ahb_q[$];
  apb_exp_t    apb_q[$];
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] slv_mem[logic [29:0]];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          setup_cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] initv(input logic [29:0] w);
    return {w, 2'b00} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic plan_t mk(input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input int as,
                               input int dw, input logic e);
    plan_t p;
    p.wr     = wr;
    p.addr   = a;
    p.wdata  = d;
    p.astall = as;
    p.dwait  = (e && dw == 0) ? 1 : dw;
    p.err    = e;
    return p;
  endfunction

  // AHB slave: address stalls, data waits, two-cycle ERROR
  initial begin
    int    sph;
    int    acnt;
    int    dcnt;
    plan_t sp;
    sph = 0; acnt = 0; dcnt = 0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(posedge HCLK);
      #2;
      if (HRESET) begin
        sph = 0; HREADY = 1'b1; HRESP = 1'b0;
      end else if (sph == 2) begin
        if (dcnt > 0) begin
          HREADY = 1'b0;
          HRESP  = sp.err && (dcnt == 1);
          HRDATA = $urandom;
          dcnt--;
        end else begin
          HREADY = 1'b1;
          HRESP  = sp.err;
          sph    = 0;
          if (sp.wr) begin
            HRDATA = $urandom;
            if (!sp.err) slv_mem[HADDR[31:2]] = HWDATA;
          end else begin
            HRDATA = slv_mem.exists(HADDR[31:2]) ?
                     slv_mem[HADDR[31:2]] : initv(HADDR[31:2]);
          end
        end
      end else begin
        if (sph == 0 && HTRANS == 2'b10 && plan_q.size() > 0) begin
          sp   = plan_q.pop_front();
          sph  = 1;
          acnt = sp.astall;
        end
        HRESP  = 1'b0;
        HRDATA = $urandom;
        if (sph == 1) begin
          if (acnt > 0) begin
            HREADY = 1'b0; acnt--;
          end else begin
            HREADY = 1'b1; sph = 2; dcnt = sp.dwait;
          end
        end else begin
          HREADY = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // AHB-side monitor
  initial begin
    logic  dph;
    logic  prev_acc;
    plan_t dp;
    plan_t e;
    dph = 1'b0; prev_acc = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dph = 1'b0; prev_acc = 1'b0;
      end else begin
        if (prev_acc) chk("htrans_after_nonseq", 32'(HTRANS), 32'h0);
        prev_acc = 1'b0;
        if (dph && HREADY) begin
          if (dp.wr) chk("hwdata", HWDATA, dp.wdata);
          dph = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          if (ahb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_nonseq: got HADDR %h expected no transfer", HADDR);
          end else begin
            e = ahb_q.pop_front();
            chk("haddr", HADDR, {e.addr[31:2], 2'b00});
            chk("hwrite", 32'(HWRITE), 32'(e.wr));
            chk("hsize", 32'(HSIZE), 32'h2);
            chk("hburst", 32'(HBURST), 32'h0);
            chk("hprot", 32'(HPROT), 32'h3);
            chk("hmastlock", 32'(HMASTLOCK), 32'h0);
            chk("addr_latency", 32'(cyc - setup_cyc), 32'(1 + e.astall));
            dp = e; dph = 1'b1; prev_acc = 1'b1;
          end
        end
      end
    end
  end

  // APB-side monitor
  initial begin
    apb_exp_t x;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (PSEL && !PENABLE) setup_cyc = cyc;
        if (PSEL && PENABLE && PREADY) begin
          if (apb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pready: got PREADY 1 expected no completion");
          end else begin
            x = apb_q.pop_front();
            chk("prdata", PRDATA, x.prdata);
            chk("pslverr", 32'(PSLVERR), 32'(x.slverr));
            chk("apb_latency", 32'(cyc - setup_cyc), 32'(x.lat));
          end
        end
      end
    end
  end

  task automatic issue(input plan_t p, input bit abort);
    apb_exp_t    x;
    logic [29:0] w;
    int          n;
    w     = p.addr[31:2];
    x.lat = 3 + p.astall + p.dwait;
    if (p.wr) begin
      if (!p.err) ref_mem[w] = p.wdata;
    end else begin
      last_rd = ref_mem.exists(w) ? ref_mem[w] : initv(w);
    end
    x.prdata = last_rd;
    x.slverr = SLVERR_EN & p.err;
    plan_q.push_back(p);
    ahb_q.push_back(p);
    if (!abort) apb_q.push_back(x);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = p.wr;
    PADDR = p.addr; PWDATA = p.wdata;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    if (abort) begin
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (x.lat + 2) @(posedge HCLK);
    end else begin
      n = 0;
      do begin
        @(negedge HCLK); n++;
      end while (!PREADY && n < 64);
      if (!PREADY) begin
        checks++; errors++;
        $display("FAIL pready_timeout: got no PREADY expected within 64 cycles");
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = $urandom;
    repeat (n) @(posedge HCLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end expected finish before 400us");
    $fatal(1);
  end

  initial begin
    plan_t p;
    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; last_rd = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    issue(mk(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 1'b0), 1'b0);
    idle(2);
    issue(mk(1'b1, 32'h2000_0010, 32'h1234_5678, 0, 0, 1'b0), 1'b0);
    idle(1);
    issue(mk(1'b0, 32'h2000_0010, $urandom, 0, 3, 1'b0), 1'b0);
    idle(1);
    issue(mk(1'b0, 32'h3000_0007, $urandom, 1, 0, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h2000_0010, $urandom, 0, 1, 1'b1), 1'b0);
    issue(mk(1'b1, 32'h0000_0000, 32'h1111_1111, 0, 0, 1'b0), 1'b0);
    issue(mk(1'b1, 32'h0000_0004, 32'h2222_2222, 0, 0, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h0000_0000, $urandom, 0, 0, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h0000_0004, $urandom, 0, 0, 1'b0), 1'b0);
    idle(1);

    // access phase with no setup phase must not start a transfer
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1;
    repeat (4) begin
      @(negedge HCLK);
      chk("stray_penable_htrans", 32'(HTRANS), 32'h0);
    end
    idle(1);

    issue(mk(1'b0, 32'h2000_0010, $urandom, 1, 2, 1'b0), 1'b1);
    idle(1);
    issue(mk(1'b0, 32'h1000_0004, $urandom, 0, 0, 1'b0), 1'b0);

    for (int i = 0; i < 60; i++) begin
      p = mk(1'($urandom_range(0, 1)),
             32'h4000_0000 | (32'($urandom_range(0, 15)) << 2) |
             32'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom_range(0, 4) == 0));
      issue(p, 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    issue(mk(1'b0, 32'h1000_0004, $urandom, 0, 0, 1'b0), 1'b0);
    idle(1);
    p = mk(1'b0, 32'h1000_0004, 32'h0, 0, 8, 1'b0);
    plan_q.push_back(p);
    ahb_q.push_back(p);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = p.addr;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    chk("midrst_htrans", 32'(HTRANS), 32'h0);
    chk("midrst_pready", 32'(PREADY), 32'h0);
    chk("midrst_prdata", PRDATA, 32'h0);
    chk("midrst_haddr", HADDR, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    issue(mk(1'b1, 32'h0000_0008, 32'h3333_3333, 0, 1, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h1000_0004, $urandom, 1, 1, 1'b0), 1'b0);
    idle(4);

    chk("apb_q_drained", 32'(apb_q.size()), 32'h0);
    chk("ahb_q_drained", 32'(ahb_q.size()), 32'h0);
    chk("plan_q_drained", 32'(plan_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
